bf_io: RTL and testbench
========================

# bf_io

Byte-stream I/O responder for the BF core: it sits on the core's `out`/`out_enable` and `in` ports and connects them to a host-side valid/ready byte interface. It has two show-ahead FIFOs. The TX FIFO carries core output to the host. The RX FIFO carries host bytes into the core. The block gives the core the flow-control status it needs to stall `.` and `,`, and it flags any lost or missing byte with sticky error bits.

## Interface
- `FIFO_DEPTH`, default 4: entries per FIFO. Must be a power of two, ≥ 2.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `out`  in  8  byte from core `.` instruction.
- `out_enable`  in  1  one-cycle push strobe from core.
- `out_ready`  out  1  TX FIFO not full; the core must hold `.` while low.
- `in`  out  8  RX FIFO head byte; 8'h00 when RX is empty.
- `in_valid`  out  1  RX FIFO not empty.
- `in_take`  in  1  core consumes the head byte (`,` executed).
- `host_tx_data`  out  8  TX head byte; 8'h00 when TX is empty.
- `host_tx_valid`  out  1  TX FIFO not empty.
- `host_tx_ready`  in  1  host accepts the TX byte.
- `host_rx_data`  in  8  byte from host.
- `host_rx_valid`  in  1  host offers a byte.
- `host_rx_ready`  out  1  RX FIFO not full.
- `out_overflow`  out  1  sticky: `out_enable` arrived while `out_ready` was low.
- `in_underflow`  out  1  sticky: `in_take` arrived while `in_valid` was low.

## Operation
- Each FIFO has a write pointer, a read pointer and a count. Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo the depth. Count is one bit wider and ranges from 0 to FIFO_DEPTH.
- All status flags are decoded from the registered count only: full = (count == FIFO_DEPTH), empty = (count == 0).
- A push is accepted when push strobe && !full. A pop is accepted when pop strobe && !empty.
- Accepted push and pop in the same cycle: count is unchanged and both pointers advance.
- Push while full is rejected, even if a pop happens in the same cycle. The ready signal was already low, so the strobe was invalid.
- Pop while empty is ignored and no pointer moves.
- TX FIFO wiring: push = `out_enable`, pop = `host_tx_valid && host_tx_ready`.
- RX FIFO wiring: push = `host_rx_valid && host_rx_ready`, pop = `in_take`.
- `out_enable && !out_ready` drops the byte and sets `out_overflow`.
- `in_take && !in_valid` sets `in_underflow`. `in` reads 8'h00 in that case.
- Sticky flags clear only on reset.
- Byte order is strictly FIFO in both directions. Data is passed unmodified.

## Timing
- Reset values: `out_ready`=1, `host_rx_ready`=1, `in_valid`=0, `host_tx_valid`=0, `in`=8'h00, `host_tx_data`=8'h00, both sticky flags 0. Pointers and counts are 0.
- FIFO storage contents are not reset. Outputs are gated to 8'h00 while the FIFO is empty.
- Latency from push to head visible at the far side is 1 cycle: a byte pushed at edge N appears at the output, with valid high, after edge N.
- Read is show-ahead: the head data is combinational from `mem[rd_ptr]`, qualified by !empty.
- A ready output goes low in the cycle after the FIFO reaches full. It goes high in the cycle after the pop that frees an entry.
- There is no combinational path from any input strobe to any ready or valid output.
- Reset asserted mid-transfer empties both FIFOs the next edge. Bytes in flight are discarded and no error flag is set.
- Throughput: one push and one pop per FIFO per cycle, sustained.

## Structure
- Shared package `bf_pkg` holds:
  - `localparam int unsigned BF_BYTE_W = 8`
  - a `bf_byte_t` typedef
  - the default `FIFO_DEPTH`
- Sub-module `bf_byte_fifo` implements the generic show-ahead FIFO with ports `clock`, `reset`, `push`, `push_data`, `pop`, `head`, `full`, `empty`. It is instantiated twice.
- The top level contains only the wiring, the output gating and the two sticky-flag registers.

## Test plan
- **Reset state:** hold `reset` for 2 cycles, then release. All outputs must match the reset values: readies 1, valids 0, data 8'h00, flags 0.
- **TX in order:** core pushes 8'h48, 8'h69 on consecutive cycles with `host_tx_ready`=1. `host_tx_data` must show 8'h48 then 8'h69 on consecutive cycles, then `host_tx_valid`=0.
- **TX overflow:** `host_tx_ready`=0. Push 5 bytes 8'h01..8'h05 with depth 4. `out_ready` must drop after the 4th push and `out_overflow` must go to 1. Draining must return exactly 8'h01..8'h04.
- **RX underflow:** with RX empty, assert `in_take`. Required: `in`=8'h00, `in_underflow`=1, `in_valid` stays 0.
- **Simultaneous push/pop at full:** fill RX with 8'hA0..8'hA3. Drive `in_take` and `host_rx_valid` (8'hB0) in the same cycle. Required: the pop is accepted, the host byte is not accepted, and the head becomes 8'hA1. The next cycle accepts 8'hB0, which appears after 8'hA3.
- **Reset mid-operation:** with 3 bytes in TX and `out_overflow` set, pulse `reset`. The next cycle must show `host_tx_valid`=0 and `out_overflow`=0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the BF core I/O slice.
//   BF_BYTE_W     : width of a stream byte
//   bf_byte_t     : byte type used on every data port
//   BF_FIFO_DEPTH : default entries per byte FIFO (power of two, >= 2)
package bf_pkg;

  localparam int unsigned BF_BYTE_W     = 8;
  localparam int unsigned BF_FIFO_DEPTH = 4;

  typedef logic [BF_BYTE_W-1:0] bf_byte_t;

endpackage

// File: rtl/bf_byte_fifo.sv
// Generic show-ahead byte FIFO.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, push_data : write strobe and byte; ignored while full
//   pop          : read strobe; ignored while empty
//   head         : byte at the read pointer (not gated; valid only when !empty)
//   full, empty  : decoded from the registered count only
module bf_byte_fifo
  import bf_pkg::*;
#(
  parameter int unsigned DEPTH = BF_FIFO_DEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  bf_byte_t push_data,
  input  logic     pop,
  output bf_byte_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bf_byte_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  bf_byte_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push while full is rejected even if a pop lands in the same cycle:
  // the producer saw ready low, so its strobe is not a valid transfer.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately not reset; readers gate the head with !empty.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bf_io.sv
// Byte-stream I/O responder between the BF core and a host valid/ready port.
// Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   out, out_enable, out_ready   : core -> TX FIFO push side
//   in, in_valid, in_take        : RX FIFO head -> core (show-ahead)
//   host_tx_data/valid/ready     : TX FIFO head -> host
//   host_rx_data/valid/ready     : host -> RX FIFO push side
//   out_overflow, in_underflow   : sticky error flags, cleared only by reset
module bf_io
  import bf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = BF_FIFO_DEPTH
) (
  input  logic     clock,
  input  logic     reset,
  input  bf_byte_t out,
  input  logic     out_enable,
  output logic     out_ready,
  output bf_byte_t in,
  output logic     in_valid,
  input  logic     in_take,
  output bf_byte_t host_tx_data,
  output logic     host_tx_valid,
  input  logic     host_tx_ready,
  input  bf_byte_t host_rx_data,
  input  logic     host_rx_valid,
  output logic     host_rx_ready,
  output logic     out_overflow,
  output logic     in_underflow
);

  bf_byte_t tx_head, rx_head;
  logic     tx_full, tx_empty, rx_full, rx_empty;
  logic     out_overflow_q, out_overflow_d;
  logic     in_underflow_q, in_underflow_d;

  bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_enable),
    .push_data (out),
    .pop       (host_tx_valid && host_tx_ready),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (host_rx_valid && host_rx_ready),
    .push_data (host_rx_data),
    .pop       (in_take),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign out_ready     = !tx_full;
  assign host_tx_valid = !tx_empty;
  assign host_tx_data  = tx_empty ? '0 : tx_head;
  assign host_rx_ready = !rx_full;
  assign in_valid      = !rx_empty;
  assign in            = rx_empty ? '0 : rx_head;
  assign out_overflow  = out_overflow_q;
  assign in_underflow  = in_underflow_q;

  always_comb begin
    out_overflow_d = out_overflow_q | (out_enable && tx_full);
    in_underflow_d = in_underflow_q | (in_take && rx_empty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_overflow_q <= 1'b0;
      in_underflow_q <= 1'b0;
    end else begin
      out_overflow_q <= out_overflow_d;
      in_underflow_q <= in_underflow_d;
    end
  end

endmodule

// File: tb/tb_bf_io.sv
module tb_bf_io;
  import bf_pkg::*;

  logic     clock = 1'b0;
  logic     reset;
  bf_byte_t out;
  logic     out_enable;
  logic     out_ready;
  bf_byte_t in;
  logic     in_valid;
  logic     in_take;
  bf_byte_t host_tx_data;
  logic     host_tx_valid;
  logic     host_tx_ready;
  bf_byte_t host_rx_data;
  logic     host_rx_valid;
  logic     host_rx_ready;
  logic     out_overflow;
  logic     in_underflow;

  bf_io #(.FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .out           (out),
    .out_enable    (out_enable),
    .out_ready     (out_ready),
    .in            (in),
    .in_valid      (in_valid),
    .in_take       (in_take),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .out_overflow  (out_overflow),
    .in_underflow  (in_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    // inputs held for one cycle
    logic     rst;
    logic     oe;
    bf_byte_t od;
    logic     tr;
    logic     rv;
    bf_byte_t rd;
    logic     tk;
    // outputs expected after that edge
    logic     ordy;
    logic     ival;
    bf_byte_t idat;
    logic     tval;
    bf_byte_t tdat;
    logic     rrdy;
    logic     ovf;
    logic     unf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(
    input logic rst, input logic oe, input bf_byte_t od, input logic tr,
    input logic rv, input bf_byte_t rd, input logic tk,
    input logic ordy, input logic ival, input bf_byte_t idat, input logic tval,
    input bf_byte_t tdat, input logic rrdy, input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.oe = oe; v.od = od; v.tr = tr; v.rv = rv; v.rd = rd; v.tk = tk;
    v.ordy = ordy; v.ival = ival; v.idat = idat; v.tval = tval; v.tdat = tdat;
    v.rrdy = rrdy; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic apply(input string tag, input int idx, input vec_t v);
    logic [22:0] got, want;
    reset         = v.rst;
    out_enable    = v.oe;
    out           = v.od;
    host_tx_ready = v.tr;
    host_rx_valid = v.rv;
    host_rx_data  = v.rd;
    in_take       = v.tk;
    @(posedge clock);
    #1;
    got  = {out_ready, in_valid, in, host_tx_valid, host_tx_data,
            host_rx_ready, out_overflow, in_underflow};
    want = {v.ordy, v.ival, v.idat, v.tval, v.tdat, v.rrdy, v.ovf, v.unf};
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s[%0d]: got ordy=%b ival=%b in=%h tval=%b tdat=%h rrdy=%b ovf=%b unf=%b, want ordy=%b ival=%b in=%h tval=%b tdat=%h rrdy=%b ovf=%b unf=%b",
               tag, idx, out_ready, in_valid, in, host_tx_valid, host_tx_data,
               host_rx_ready, out_overflow, in_underflow,
               v.ordy, v.ival, v.idat, v.tval, v.tdat, v.rrdy, v.ovf, v.unf);
    end
  endtask

  initial begin
    reset = 1'b1; out = '0; out_enable = 1'b0; in_take = 1'b0;
    host_tx_ready = 1'b0; host_rx_data = '0; host_rx_valid = 1'b0;

    //            rst oe od    tr rv rd    tk   ordy ival idat  tval tdat  rrdy ovf unf
    // reset state
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
    // TX in order
    vecs.push_back(mk(0, 1, 8'h48, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h48, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h69, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h69, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
    // TX overflow
    vecs.push_back(mk(0, 1, 8'h01, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h01, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h02, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h01, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h03, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h01, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 8'h01, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 8'h01, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h02, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h03, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'h04, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 1, 0));
    // RX underflow
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 8'h00, 1, 1, 1));
    // RX fill, then simultaneous pop and host offer at full
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA0, 0,  1, 1, 8'hA0, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA1, 0,  1, 1, 8'hA0, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA2, 0,  1, 1, 8'hA0, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA3, 0,  1, 1, 8'hA0, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hB0, 1,  1, 1, 8'hA1, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'hB0, 0,  1, 1, 8'hA1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 1, 8'hA2, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 1, 8'hA3, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 1, 8'hB0, 0, 8'h00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 8'h00, 1, 1, 1));
    // reset mid-operation: 3 bytes in TX, flags set, strobes during reset ignored
    vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hAA, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'hBB, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hAA, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'hCC, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hAA, 1, 1, 1));
    vecs.push_back(mk(1, 1, 8'hDD, 0, 1, 8'hEE, 1,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 0, 0));

    foreach (vecs[i]) apply("tbl", i, vecs[i]);

    // TX: push at full with a simultaneous host pop is still rejected
    apply("txfull_pop", 0, mk(0, 1, 8'hD0, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD0, 1, 0, 0));
    apply("txfull_pop", 1, mk(0, 1, 8'hD1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD0, 1, 0, 0));
    apply("txfull_pop", 2, mk(0, 1, 8'hD2, 0, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD0, 1, 0, 0));
    apply("txfull_pop", 3, mk(0, 1, 8'hD3, 0, 0, 8'h00, 0,  0, 0, 8'h00, 1, 8'hD0, 1, 0, 0));
    apply("txfull_pop", 4, mk(0, 1, 8'hD4, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD1, 1, 1, 0));
    apply("txfull_pop", 5, mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD2, 1, 1, 0));
    apply("txfull_pop", 6, mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 1, 8'hD3, 1, 1, 0));
    apply("txfull_pop", 7, mk(0, 0, 8'h00, 1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 8'h00, 1, 1, 0));

    // RX: sustained push+pop every cycle with one byte in flight
    apply("rx_stream", 0, mk(0, 0, 8'h00, 0, 1, 8'hE0, 0,  1, 1, 8'hE0, 0, 8'h00, 1, 1, 0));
    apply("rx_stream", 1, mk(0, 0, 8'h00, 0, 1, 8'hE1, 1,  1, 1, 8'hE1, 0, 8'h00, 1, 1, 0));
    apply("rx_stream", 2, mk(0, 0, 8'h00, 0, 1, 8'hE2, 1,  1, 1, 8'hE2, 0, 8'h00, 1, 1, 0));
    apply("rx_stream", 3, mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 8'h00, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
